// File: rtl/jtag_host_seq.sv
// Host-side JTAG sequencer: turns TAP-reset / IR-scan / DR-scan / idle-wait commands
// into registered TMS/TDI streams on TCK (clk) and captures TDO into a response word.
module jtag_host_seq #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               TRST_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data
);

  localparam int               IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(5);

  typedef enum logic [2:0] {
    H_IDLE  = 3'd0,
    H_PRE   = 3'd1,
    H_SHIFT = 3'd2,
    H_POST  = 3'd3,
    H_WAIT  = 3'd4,
    H_RST   = 3'd5,
    H_DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [4:0]         pat_q, pat_d;
  logic [2:0]         plen_q, plen_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               in_tlr_q, in_tlr_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               ready_q, valid_q;
  logic [LEN_W-1:0]   len_clamp;

  // The state register always describes the bit currently on TMS/TDI, so the
  // output flops are loaded from the decoded next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    pat_d    = pat_q;
    plen_d   = plen_q;
    data_d   = data_q;
    rsp_d    = rsp_q;
    tms_d    = 1'b0;
    tdi_d    = 1'b0;
    len_clamp = (cmd_len > MAX_L) ? MAX_L : cmd_len;

    case (state_q)
      H_IDLE: begin
        if (cmd_valid) begin
          data_d = cmd_data;
          rsp_d  = '0;
          cnt_d  = '0;
          case (cmd_op)
            2'b00: state_d = H_RST;
            2'b01, 2'b10: begin
              state_d = H_PRE;
              len_d   = (len_clamp == '0) ? ONE_L : len_clamp;
              // Pre-scan TMS pattern, LSB first; a leading 0 leaves Test-Logic-Reset.
              pat_d   = ((cmd_op == 2'b01) ? 5'b00011 : 5'b00001) << in_tlr_q;
              plen_d  = ((cmd_op == 2'b01) ? 3'd4 : 3'd3) + {2'b00, in_tlr_q};
            end
            default: begin
              len_d   = len_clamp + {{(LEN_W-1){1'b0}}, in_tlr_q};
              state_d = (len_d == '0) ? H_DONE : H_WAIT;
            end
          endcase
        end else begin
          state_d = H_IDLE;
        end
      end
      H_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = H_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      H_PRE: begin
        if (cnt_q == LEN_W'(plen_q) - ONE_L) begin
          state_d = H_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      H_SHIFT: begin
        // The TAP consumes the TDI bit now on the wire at this edge.
        rsp_d[cnt_q[IDX_W-1:0]] = TDO;
        if (cnt_q == len_q - ONE_L) begin
          state_d = H_POST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      H_POST: begin
        if (cnt_q == ONE_L) begin
          state_d = H_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      H_WAIT: begin
        if (cnt_q == len_q - ONE_L) begin
          state_d = H_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      H_DONE:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase

    in_tlr_d = (state_d == H_DONE) ? 1'b0 : in_tlr_q;

    case (state_d)
      H_IDLE:  tms_d = in_tlr_d;
      H_RST:   tms_d = (cnt_d != RST_LAST);
      H_PRE:   tms_d = pat_d[cnt_d[2:0]];
      H_SHIFT: begin
        tms_d = (cnt_d == len_d - ONE_L);
        tdi_d = data_d[cnt_d[IDX_W-1:0]];
      end
      H_POST:  tms_d = (cnt_d == '0);
      default: tms_d = 1'b0;
    endcase
  end

  // State, command latches and registered outputs; TRST_n also resets the TAP model flag.
  always_ff @(posedge clk or negedge TRST_n) begin
    if (!TRST_n) begin
      state_q  <= H_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      pat_q    <= '0;
      plen_q   <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
      in_tlr_q <= 1'b1;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      plen_q   <= plen_d;
      data_q   <= data_d;
      rsp_q    <= rsp_d;
      in_tlr_q <= in_tlr_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      ready_q  <= (state_d == H_IDLE);
      valid_q  <= (state_d == H_DONE);
    end
  end

  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign cmd_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = rsp_q;

endmodule
